mem_access_sequencer: RTL and testbench

- Sits between the control unit and the 512x8 byte-addressed RAM.
- Accepts one memory request at a time from the control unit and drives the RAM's Enable/OpCode/address/data pins.
- Waits on MFC and returns the read data.
- Sequences the multi-access operations the RAM does not implement natively: load doubleword, store doubleword and SWAP.
- Enforces alignment and opcode legality before any RAM access.

---
 rtl/mem_access_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Takes one memory request at a time from the control unit and runs it
//   against a 512x8 byte-addressed RAM through its Enable/OpCode/MFC
//   handshake. LDD, STD and SWAP are split into two RAM accesses.
//   Misaligned requests and unknown opcodes are rejected with a Trap pulse
//   before any RAM access.
//
// Build option:
//   MEMSEQ_MFC_SYNC_EN - when defined, Mem_MFC goes through a two-flop
//   synchronizer. An access may then only complete after the synchronized
//   MFC has been seen low at least once since Enable rose.
//
// Ports:
//   Clk, Clr            clock (rising edge), asynchronous active-low reset
//   Req/ReqOp/ReqAddr   request strobe, opcode and byte address
//   ReqData0/ReqData1   store data (ReqData1 is the odd word of STD)
//   Busy/Done/Trap      status: in progress, completion pulse, reject pulse
//   RdData0/RdData1     load results (RdData1 is the odd word of LDD)
//   Mem_*               RAM Enable/OpCode/Address/DataIn out, DataOut/MFC in
module mem_access_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OP_W  = 6
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Req,
  input  logic [OP_W-1:0]   ReqOp,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData0,
  input  logic [DATA_W-1:0] ReqData1,
  output logic              Busy,
  output logic              Done,
  output logic              Trap,
  output logic [DATA_W-1:0] RdData0,
  output logic [DATA_W-1:0] RdData1,
  output logic              Mem_Enable,
  output logic [OP_W-1:0]   Mem_OpCode,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_DataIn,
  input  logic [DATA_W-1:0] Mem_DataOut,
  input  logic              Mem_MFC
);

  localparam int unsigned STEP_W = 2;

  localparam logic [OP_W-1:0] OP_LW   = 6'b000000;
  localparam logic [OP_W-1:0] OP_LUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_LUH  = 6'b000010;
  localparam logic [OP_W-1:0] OP_LDD  = 6'b000011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b000100;
  localparam logic [OP_W-1:0] OP_SB   = 6'b000101;
  localparam logic [OP_W-1:0] OP_SH   = 6'b000110;
  localparam logic [OP_W-1:0] OP_STD  = 6'b000111;
  localparam logic [OP_W-1:0] OP_LSB  = 6'b001001;
  localparam logic [OP_W-1:0] OP_LSH  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SWAP = 6'b001111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [OP_W-1:0]     lat_op;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data0;
  logic [DATA_W-1:0]   lat_data1;

  // Opcode classification helpers.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_LUB, OP_LUH, OP_LDD, OP_SW, OP_SB, OP_SH, OP_STD,
      OP_LSB, OP_LSH, OP_SWAP: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic op_dword(input logic [OP_W-1:0] op);
    return (op == OP_LDD) || (op == OP_STD);
  endfunction

  function automatic logic op_two_step(input logic [OP_W-1:0] op);
    return op_dword(op) || (op == OP_SWAP);
  endfunction

  function automatic logic op_load(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_LUB, OP_LUH, OP_LDD, OP_LSB, OP_LSH, OP_SWAP: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // RAM opcode for a given step of a request.
  function automatic logic [OP_W-1:0] step_opcode(input logic [OP_W-1:0]   op,
                                                  input logic [STEP_W-1:0] stp);
    case (op)
      OP_LDD:  return OP_LW;
      OP_STD:  return OP_SW;
      OP_SWAP: return (stp == STEP_W'(1)) ? OP_SW : OP_LW;
      default: return op;
    endcase
  endfunction

  // Doubleword ops touch A then A+4 (wraps modulo 2^ADDR_W).
  function automatic logic [ADDR_W-1:0] step_addr(input logic [OP_W-1:0]   op,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [STEP_W-1:0] stp);
    if (op_dword(op) && (stp == STEP_W'(1))) return addr + ADDR_W'(4);
    return addr;
  endfunction

  function automatic logic [DATA_W-1:0] step_data(input logic [OP_W-1:0]   op,
                                                  input logic [DATA_W-1:0] d0,
                                                  input logic [DATA_W-1:0] d1,
                                                  input logic [STEP_W-1:0] stp);
    if ((op == OP_STD) && (stp == STEP_W'(1))) return d1;
    return d0;
  endfunction

  logic              req_bad_c;
  logic              last_step_c;
  logic              cap0_c;
  logic              cap1_c;
  logic [STEP_W-1:0] next_step_c;
  logic              mfc_ok_c;

  assign req_bad_c   = !op_legal(ReqOp) || (ReqAddr[1:0] != 2'b00) ||
                       (op_dword(ReqOp) && ReqAddr[2]);
  assign last_step_c = op_two_step(lat_op) ? (step == STEP_W'(1)) : (step == STEP_W'(0));
  // Step 0 of any load-type op fills RdData0; only LDD's second read fills RdData1.
  assign cap0_c      = op_load(lat_op) && (step == STEP_W'(0));
  assign cap1_c      = (lat_op == OP_LDD) && (step == STEP_W'(1));
  assign next_step_c = step + STEP_W'(1);

`ifdef MEMSEQ_MFC_SYNC_EN
  logic [1:0] mfc_sync;
  logic       mfc_low_seen;

  // Two-flop synchronizer for the RAM completion flag.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mfc_sync <= 2'b00;
    end else begin
      mfc_sync <= {mfc_sync[0], Mem_MFC};
    end
  end

  // Remembers that MFC went low during this access, so a leftover high
  // from the previous access cannot complete the new one.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mfc_low_seen <= 1'b0;
    end else if (state != S_ISSUE) begin
      mfc_low_seen <= 1'b0;
    end else if (!mfc_sync[1]) begin
      mfc_low_seen <= 1'b1;
    end
  end

  assign mfc_ok_c = mfc_sync[1] && mfc_low_seen;
`else
  assign mfc_ok_c = Mem_MFC;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state       <= S_IDLE;
      step        <= '0;
      lat_op      <= '0;
      lat_addr    <= '0;
      lat_data0   <= '0;
      lat_data1   <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Trap        <= 1'b0;
      RdData0     <= '0;
      RdData1     <= '0;
      Mem_Enable  <= 1'b0;
      Mem_OpCode  <= '0;
      Mem_Address <= '0;
      Mem_DataIn  <= '0;
    end else begin
      Done <= 1'b0;
      Trap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            lat_op    <= ReqOp;
            lat_addr  <= ReqAddr;
            lat_data0 <= ReqData0;
            lat_data1 <= ReqData1;
            step      <= '0;
            if (req_bad_c) begin
              state <= S_DONE;
              Done  <= 1'b1;
              Trap  <= 1'b1;
            end else begin
              state       <= S_ISSUE;
              Busy        <= 1'b1;
              Mem_Enable  <= 1'b1;
              Mem_OpCode  <= step_opcode(ReqOp, STEP_W'(0));
              Mem_Address <= step_addr(ReqOp, ReqAddr, STEP_W'(0));
              Mem_DataIn  <= step_data(ReqOp, ReqData0, ReqData1, STEP_W'(0));
            end
          end
        end

        S_ISSUE: begin
          if (mfc_ok_c) begin
            if (cap0_c) RdData0 <= Mem_DataOut;
            if (cap1_c) RdData1 <= Mem_DataOut;
            Mem_Enable <= 1'b0;
            state      <= S_RELEASE;
          end
        end

        // Enable is low here for one cycle; the RAM needs that edge to
        // recognise the next access.
        S_RELEASE: begin
          if (last_step_c) begin
            state <= S_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            step        <= next_step_c;
            state       <= S_ISSUE;
            Mem_Enable  <= 1'b1;
            Mem_OpCode  <= step_opcode(lat_op, next_step_c);
            Mem_Address <= step_addr(lat_op, lat_addr, next_step_c);
            Mem_DataIn  <= step_data(lat_op, lat_data0, lat_data1, next_step_c);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: behavioural 512x8 big-endian RAM,
// a table of single requests with hand-computed results, and directed
// sequences for reset mid-operation and Req while busy.
module tb_mem_access_sequencer;

  logic        Clk;
  logic        Clr;
  logic        Req;
  logic [5:0]  ReqOp;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData0;
  logic [31:0] ReqData1;
  logic        Busy;
  logic        Done;
  logic        Trap;
  logic [31:0] RdData0;
  logic [31:0] RdData1;
  logic        Mem_Enable;
  logic [5:0]  Mem_OpCode;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_DataIn;
  logic [31:0] Mem_DataOut;
  logic        Mem_MFC;

  mem_access_sequencer dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .Req         (Req),
    .ReqOp       (ReqOp),
    .ReqAddr     (ReqAddr),
    .ReqData0    (ReqData0),
    .ReqData1    (ReqData1),
    .Busy        (Busy),
    .Done        (Done),
    .Trap        (Trap),
    .RdData0     (RdData0),
    .RdData1     (RdData1),
    .Mem_Enable  (Mem_Enable),
    .Mem_OpCode  (Mem_OpCode),
    .Mem_Address (Mem_Address),
    .Mem_DataIn  (Mem_DataIn),
    .Mem_DataOut (Mem_DataOut),
    .Mem_MFC     (Mem_MFC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- RAM model ----------------
  logic [7:0] mem [512];
  int         ram_cnt = 0;
  int         ram_wait = 0;
  bit         ram_written = 0;
  logic [8:0] ra;

  assign ra          = Mem_Address[8:0];
  assign Mem_DataOut = {mem[ra], mem[ra + 9'd1], mem[ra + 9'd2], mem[ra + 9'd3]};
  assign Mem_MFC     = Mem_Enable && (ram_cnt >= ram_wait);

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
    mem[48] = 8'hCA; mem[49] = 8'hFE; mem[50] = 8'hF0; mem[51] = 8'h0D;
    forever begin
      @(posedge Clk);
      if (!Mem_Enable) begin
        ram_cnt     <= 0;
        ram_written <= 1'b0;
      end else begin
        if (Mem_MFC && (Mem_OpCode == 6'b000100) && !ram_written) begin
          mem[ra]         <= Mem_DataIn[31:24];
          mem[ra + 9'd1]  <= Mem_DataIn[23:16];
          mem[ra + 9'd2]  <= Mem_DataIn[15:8];
          mem[ra + 9'd3]  <= Mem_DataIn[7:0];
          ram_written     <= 1'b1;
        end
        if (ram_cnt < 64) ram_cnt <= ram_cnt + 1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          done_n = 0;
  int          gap_bad = 0;
  int          stable_bad = 0;
  int          gap_run = 0;
  logic        en_prev = 1'b0;
  logic [5:0]  op_prev = '0;
  logic [31:0] addr_prev = '0;
  logic [31:0] din_prev = '0;
  logic [5:0]  log_op [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  always @(negedge Clk) begin
    if (Done) done_n++;
    if (Mem_Enable && !en_prev) begin
      log_op.push_back(Mem_OpCode);
      log_addr.push_back(Mem_Address);
      log_data.push_back(Mem_DataIn);
    end
    if (Mem_Enable && en_prev &&
        (Mem_OpCode !== op_prev || Mem_Address !== addr_prev || Mem_DataIn !== din_prev))
      stable_bad++;
    if (Busy && !Mem_Enable) gap_run++;
    else begin
      if (gap_run > 1) gap_bad++;
      gap_run = 0;
    end
    en_prev   = Mem_Enable;
    op_prev   = Mem_OpCode;
    addr_prev = Mem_Address;
    din_prev  = Mem_DataIn;
  end

  // ---------------- checking helpers ----------------
  int pass_n = 0;
  int chk_n  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issues one request and follows it to its Done pulse (bounded).
  // edges counts rising edges from the one that samples Req up to Done.
  task automatic run_req(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] d0, input logic [31:0] d1,
                         output int edges, output int issues,
                         output logic trap, output logic done_ok);
    logic en_p;
    @(negedge Clk);
    Req = 1'b1; ReqOp = op; ReqAddr = addr; ReqData0 = d0; ReqData1 = d1;
    edges = 0; issues = 0; trap = 1'b0; done_ok = 1'b0; en_p = 1'b0;
    for (int k = 0; k < 200 && !done_ok; k++) begin
      @(negedge Clk);
      Req = 1'b0;
      edges++;
      if (Mem_Enable && !en_p) issues++;
      en_p = Mem_Enable;
      if (Done) begin
        done_ok = 1'b1;
        trap    = Trap;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] d0;
    logic [31:0] d1;
    int          wait_c;
    logic        trap;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          edges;
    int          issues;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] d0, input logic [31:0] d1, input int wait_c,
                              input logic trap, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int edges, input int issues);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.d0 = d0; v.d1 = d1; v.wait_c = wait_c;
    v.trap = trap; v.rd0 = rd0; v.rd1 = rd1; v.edges = edges; v.issues = issues;
    return v;
  endfunction

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    int          edges;
    int          issues;
    logic        trap;
    logic        done_ok;
    int          base_done;
    int          base_log;
    int          rises;
    logic        en_p;
    logic        reached;

    Clr = 1'b0; Req = 1'b0; ReqOp = '0; ReqAddr = '0; ReqData0 = '0; ReqData1 = '0;

    // Single op: Done 4 cycles after the Req cycle (3 edges incl. sampling edge);
    // two-step op: 6 cycles (5 edges); each wait cycle adds one edge per access.
    vecs[0]  = mk("lw_10",     6'b000000, 32'h10, 32'h0, 32'h0, 0, 1'b0,
                  32'hDEADBEEF, 32'h0, 3, 1);
    vecs[1]  = mk("std_20",    6'b000111, 32'h20, 32'h11223344, 32'h55667788, 0, 1'b0,
                  32'hDEADBEEF, 32'h0, 5, 2);
    vecs[2]  = mk("ldd_20",    6'b000011, 32'h20, 32'h0, 32'h0, 0, 1'b0,
                  32'h11223344, 32'h55667788, 5, 2);
    vecs[3]  = mk("swap_30",   6'b001111, 32'h30, 32'h0000ABCD, 32'h0, 0, 1'b0,
                  32'hCAFEF00D, 32'h55667788, 5, 2);
    vecs[4]  = mk("lw_30",     6'b000000, 32'h30, 32'h0, 32'h0, 0, 1'b0,
                  32'h0000ABCD, 32'h55667788, 3, 1);
    vecs[5]  = mk("lw_12_mis", 6'b000000, 32'h12, 32'h0, 32'h0, 0, 1'b1,
                  32'h0000ABCD, 32'h55667788, 1, 0);
    vecs[6]  = mk("ldd_24_mis", 6'b000011, 32'h24, 32'h0, 32'h0, 0, 1'b1,
                  32'h0000ABCD, 32'h55667788, 1, 0);
    vecs[7]  = mk("op_08_ill", 6'b001000, 32'h40, 32'h0, 32'h0, 0, 1'b1,
                  32'h0000ABCD, 32'h55667788, 1, 0);
    vecs[8]  = mk("lw_10_w2",  6'b000000, 32'h10, 32'h0, 32'h0, 2, 1'b0,
                  32'hDEADBEEF, 32'h55667788, 5, 1);
    vecs[9]  = mk("swap_31_mis", 6'b001111, 32'h31, 32'h0, 32'h0, 0, 1'b1,
                  32'hDEADBEEF, 32'h55667788, 1, 0);
    vecs[10] = mk("std_1f8_w1", 6'b000111, 32'h1F8, 32'h0A0B0C0D, 32'h01020304, 1, 1'b0,
                  32'hDEADBEEF, 32'h55667788, 7, 2);
    vecs[11] = mk("ldd_1f8",   6'b000011, 32'h1F8, 32'h0, 32'h0, 0, 1'b0,
                  32'h0A0B0C0D, 32'h01020304, 5, 2);

    // Reset state.
    repeat (3) @(negedge Clk);
    chk("rst_busy",   32'(Busy), 32'h0);
    chk("rst_done",   32'(Done), 32'h0);
    chk("rst_trap",   32'(Trap), 32'h0);
    chk("rst_enable", 32'(Mem_Enable), 32'h0);
    chk("rst_rd0",    RdData0, 32'h0);
    chk("rst_addr",   Mem_Address, 32'h0);
    Clr = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ram_wait = vecs[i].wait_c;
      run_req(vecs[i].op, vecs[i].addr, vecs[i].d0, vecs[i].d1, edges, issues, trap, done_ok);
      chk({vecs[i].name, "_done"},   32'(done_ok), 32'h1);
      chk({vecs[i].name, "_trap"},   32'(trap), 32'(vecs[i].trap));
      chk({vecs[i].name, "_edges"},  32'(edges), 32'(vecs[i].edges));
      chk({vecs[i].name, "_issues"}, 32'(issues), 32'(vecs[i].issues));
      chk({vecs[i].name, "_rd0"},    RdData0, vecs[i].rd0);
      chk({vecs[i].name, "_rd1"},    RdData1, vecs[i].rd1);
      @(negedge Clk);
      chk({vecs[i].name, "_done_pulse"}, 32'(Done), 32'h0);
      chk({vecs[i].name, "_busy_end"},   32'(Busy), 32'h0);
    end

    // Access order: STD writes 0x20 then 0x24; SWAP reads before writing.
    chk("log_size", 32'(log_op.size() >= 7), 32'h1);
    if (log_op.size() >= 7) begin
      chk("std_a0_addr", log_addr[1], 32'h20);
      chk("std_a0_data", log_data[1], 32'h11223344);
      chk("std_a1_addr", log_addr[2], 32'h24);
      chk("std_a1_data", log_data[2], 32'h55667788);
      chk("std_a1_op",   32'(log_op[2]), 32'h4);
      chk("ldd_a1_addr", log_addr[4], 32'h24);
      chk("swap_a0_op",  32'(log_op[5]), 32'h0);
      chk("swap_a1_op",  32'(log_op[6]), 32'h4);
      chk("swap_a1_addr", log_addr[6], 32'h30);
    end
    chk("swap_mem", {mem[48], mem[49], mem[50], mem[51]}, 32'h0000ABCD);

    // Reset during the second access of an STD.
    ram_wait = 4;
    @(negedge Clk);
    Req = 1'b1; ReqOp = 6'b000111; ReqAddr = 32'h50; ReqData0 = 32'hAAAA0001; ReqData1 = 32'hBBBB0002;
    rises = 0; en_p = 1'b0; reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      Req = 1'b0;
      if (Mem_Enable && !en_p) rises++;
      en_p = Mem_Enable;
      if (rises == 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rst_mid_reach", 32'(reached), 32'h1);
    base_done = done_n;
    #1 Clr = 1'b0;
    #1;
    chk("rst_mid_enable", 32'(Mem_Enable), 32'h0);
    chk("rst_mid_busy",   32'(Busy), 32'h0);
    chk("rst_mid_rd0",    RdData0, 32'h0);
    chk("rst_mid_rd1",    RdData1, 32'h0);
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    repeat (4) @(negedge Clk);
    chk("rst_mid_no_done", 32'(done_n - base_done), 32'h0);
    ram_wait = 0;
    run_req(6'b000000, 32'h20, 32'h0, 32'h0, edges, issues, trap, done_ok);
    chk("post_rst_done",  32'(done_ok), 32'h1);
    chk("post_rst_trap",  32'(trap), 32'h0);
    chk("post_rst_edges", 32'(edges), 32'h3);
    chk("post_rst_rd0",   RdData0, 32'h11223344);

    // Req held/pulsed while busy must be ignored.
    ram_wait  = 3;
    @(negedge Clk);
    base_done = done_n;
    base_log  = log_op.size();
    Req = 1'b1; ReqOp = 6'b000000; ReqAddr = 32'h10;
    @(negedge Clk);
    chk("busy_high", 32'(Busy), 32'h1);
    ReqAddr = 32'h30;
    @(negedge Clk);
    Req = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (Done) begin
        reached = 1'b1;
        break;
      end
    end
    chk("busy_req_done", 32'(reached), 32'h1);
    repeat (6) @(negedge Clk);
    chk("busy_req_one_done", 32'(done_n - base_done), 32'h1);
    chk("busy_req_one_access", 32'(log_op.size() - base_log), 32'h1);
    chk("busy_req_rd0", RdData0, 32'hDEADBEEF);

    // Whole-run bus properties.
    chk("enable_gap_one_cycle", 32'(gap_bad), 32'h0);
    chk("issue_fields_stable",  32'(stable_bad), 32'h0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
